// File: rtl/dac_serializer_if.sv
// Sample-word handshake between the audio datapath and the DAC serializer.
// s_data carries {left, right}; s_ready is driven by the serializer.
interface dac_serializer_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic [2*DATA_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_serializer.sv
// WM8731 DAC serializer: left-justified master mode, b_clk and dac_lr_clk
// derived from m_clk, one-deep holding buffer in front of the shift register.
module dac_serializer #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned BCLK_DIV = 8
) (
    input  logic             m_clk,
    input  logic             rst_n,
    input  logic             en,
    dac_serializer_if.slave  s_bus,
    output logic             b_clk,
    output logic             dac_lr_clk,
    output logic             dacdat,
    output logic             underrun
);

    localparam int unsigned FRAME_W   = 2 * DATA_W;
    localparam int unsigned DCNT_W    = $clog2(BCLK_DIV);
    localparam int unsigned BCNT_W    = $clog2(FRAME_W);
    localparam int unsigned DCNT_LAST = BCLK_DIV - 1;
    localparam int unsigned DCNT_FALL = BCLK_DIV / 2 - 1;
    localparam int unsigned BCNT_LAST = FRAME_W - 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_d;
    logic [DCNT_W-1:0]    dcnt, dcnt_d;
    logic [BCNT_W-1:0]    bcnt, bcnt_d;
    logic [FRAME_W-1:0]   shreg, shreg_d;
    logic [FRAME_W-1:0]   hold, hold_d;
    logic                 full, full_d;
    logic                 b_clk_d, lr_d, dacdat_d, underrun_d;
    logic                 rise;
    logic                 accept;

    assign s_bus.s_ready = !full;
    assign accept        = s_bus.s_valid && !full;

    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dcnt       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            hold       <= '0;
            full       <= 1'b0;
            b_clk      <= 1'b0;
            dac_lr_clk <= 1'b0;
            dacdat     <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_d;
            dcnt       <= dcnt_d;
            bcnt       <= bcnt_d;
            shreg      <= shreg_d;
            hold       <= hold_d;
            full       <= full_d;
            b_clk      <= b_clk_d;
            dac_lr_clk <= lr_d;
            dacdat     <= dacdat_d;
            underrun   <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state;
        dcnt_d     = dcnt;
        bcnt_d     = bcnt;
        shreg_d    = shreg;
        hold_d     = hold;
        full_d     = full;
        b_clk_d    = b_clk;
        lr_d       = dac_lr_clk;
        dacdat_d   = dacdat;
        underrun_d = 1'b0;
        rise       = 1'b0;

        // Bit-clock timing: the rise event is the divider wrap (or run entry)
        unique case (state)
            IDLE: begin
                dcnt_d   = '0;
                bcnt_d   = '0;
                b_clk_d  = 1'b0;
                lr_d     = 1'b0;
                dacdat_d = 1'b0;
                if (en) begin
                    state_d = RUN;
                    rise    = 1'b1;
                end
            end
            RUN: begin
                if (dcnt == DCNT_W'(DCNT_LAST)) begin
                    dcnt_d = '0;
                    if (bcnt == '0 && !en) begin
                        state_d  = IDLE;
                        b_clk_d  = 1'b0;
                        lr_d     = 1'b0;
                        dacdat_d = 1'b0;
                    end else begin
                        rise = 1'b1;
                    end
                end else begin
                    dcnt_d = dcnt + DCNT_W'(1);
                    if (dcnt == DCNT_W'(DCNT_FALL)) b_clk_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Data and frame clock advance only on b_clk rising edges
        if (rise) begin
            b_clk_d = 1'b1;
            bcnt_d  = (bcnt == BCNT_W'(BCNT_LAST)) ? '0 : bcnt + BCNT_W'(1);
            if (bcnt == '0) begin
                lr_d = 1'b1;
                if (full) begin
                    dacdat_d = hold[FRAME_W-1];
                    shreg_d  = {hold[FRAME_W-2:0], 1'b0};
                    full_d   = 1'b0;
                end else begin
                    dacdat_d   = 1'b0;
                    shreg_d    = '0;
                    underrun_d = 1'b1;
                end
            end else begin
                dacdat_d = shreg[FRAME_W-1];
                shreg_d  = {shreg[FRAME_W-2:0], 1'b0};
                if (bcnt == BCNT_W'(DATA_W)) lr_d = 1'b0;
            end
        end

        // Accept only into an empty buffer, so it never races the frame-start unload
        if (accept) begin
            hold_d = s_bus.s_data;
            full_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer: frame-timing reference model checked every cycle,
// plus a b_clk-falling-edge receiver whose frames are checked against literals.
`timescale 1ns/1ps
module tb_dac_serializer;

    logic m_clk = 1'b0;
    logic rst_n;
    logic en;
    logic b_clk, dac_lr_clk, dacdat, underrun;

    dac_serializer_if #(.DATA_W(16)) bus ();

    dac_serializer #(.DATA_W(16), .BCLK_DIV(8)) dut (
        .m_clk      (m_clk),
        .rst_n      (rst_n),
        .en         (en),
        .s_bus      (bus),
        .b_clk      (b_clk),
        .dac_lr_clk (dac_lr_clk),
        .dacdat     (dacdat),
        .underrun   (underrun)
    );

    always #40.69 m_clk = ~m_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: position in frame is plain cycle arithmetic since the frame start
    logic        m_run, m_full, m_fs, m_acc, m_ur;
    int          m_t;
    logic [31:0] m_cur, m_hold;
    logic        e_b, e_lr, e_d;
    int          e_bit;

    // Receiver: 32 samples on b_clk falling edges after dac_lr_clk rises
    logic [31:0] rx_q[$];
    logic [31:0] rx_sh;
    int          rx_cnt;
    logic        rx_on, rx_last_lr;
    int          ur_cnt = 0;

    always @(negedge b_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_on = 1'b0; rx_cnt = 0; rx_last_lr = 1'b0; rx_sh = '0;
        end else begin
            if (dac_lr_clk && !rx_last_lr) begin
                rx_on = 1'b1; rx_cnt = 0; rx_sh = '0;
            end
            rx_last_lr = dac_lr_clk;
            if (rx_on) begin
                rx_sh = {rx_sh[30:0], dacdat};
                rx_cnt++;
                if (rx_cnt == 32) begin
                    rx_q.push_back(rx_sh);
                    rx_on = 1'b0;
                end
            end
        end
    end

    always @(negedge m_clk) if (underrun === 1'b1) ur_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        while (bus.s_ready !== 1'b1 && n < 2000) begin
            @(negedge m_clk);
            n++;
        end
        check("send_ready_timeout", 32'(n >= 2000), 32'd0);
        bus.s_data  = w;
        bus.s_valid = 1'b1;
        @(negedge m_clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] w);
        bus.s_data  = w;
        bus.s_valid = 1'b1;
        @(negedge m_clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_bclk"}, 32'(b_clk), 32'd0);
        check({tag, "_lr"},   32'(dac_lr_clk), 32'd0);
        check({tag, "_dat"},  32'(dacdat), 32'd0);
    endtask

    initial begin
        int rx_base, ur_base, bhigh, lrhigh;
        rst_n       = 1'b0;
        en          = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        m_run = 0; m_full = 0; m_t = 0; m_cur = '0; m_hold = '0; m_ur = 0;

        fork
            begin : compare
                forever begin
                    @(posedge m_clk);
                    m_fs = 1'b0;
                    m_ur = 1'b0;
                    if (!rst_n) begin
                        m_run = 0; m_full = 0; m_t = 0; m_cur = '0;
                    end else begin
                        m_acc = bus.s_valid && !m_full;
                        if (!m_run) begin
                            if (en) begin m_run = 1; m_t = 0; m_fs = 1; end
                        end else begin
                            m_t++;
                            if (m_t == 256) begin
                                m_t = 0;
                                if (en) m_fs = 1; else m_run = 0;
                            end
                        end
                        if (m_fs) begin
                            m_ur   = !m_full;
                            m_cur  = m_full ? m_hold : 32'd0;
                            m_full = 1'b0;
                        end
                        if (m_acc) begin m_full = 1'b1; m_hold = bus.s_data; end
                    end
                    #1;
                    if (m_run) begin
                        e_bit = m_t / 8;
                        e_b   = (m_t % 8) < 4;
                        e_lr  = e_bit < 16;
                        e_d   = m_cur[31 - e_bit];
                    end else begin
                        e_b = 0; e_lr = 0; e_d = 0;
                    end
                    check("b_clk",      32'(b_clk),      32'(e_b));
                    check("dac_lr_clk", 32'(dac_lr_clk), 32'(e_lr));
                    check("dacdat",     32'(dacdat),     32'(e_d));
                    check("underrun",   32'(underrun),   32'(m_ur));
                    check("s_ready",    32'(bus.s_ready), 32'(!m_full));
                end
            end
            begin : stimulus
                // Reset values
                #10;
                check_idle_outputs("rst");
                check("rst_underrun", 32'(underrun), 32'd0);
                check("rst_ready", 32'(bus.s_ready), 32'd1);
                repeat (3) @(negedge m_clk);
                rst_n = 1'b1;
                repeat (3) @(negedge m_clk);

                // Free-running with no data: two all-zero frames, one underrun each
                rx_base = rx_q.size(); ur_base = ur_cnt; bhigh = 0; lrhigh = 0;
                en = 1'b1;
                repeat (512) begin
                    @(negedge m_clk);
                    bhigh  += int'(b_clk);
                    lrhigh += int'(dac_lr_clk);
                end
                en = 1'b0;
                repeat (300) @(negedge m_clk);
                check("clk_bclk_high", 32'(bhigh), 32'd256);
                check("clk_lr_high", 32'(lrhigh), 32'd256);
                check("clk_ur_count", 32'(ur_cnt - ur_base), 32'd2);
                check("clk_frames", 32'(rx_q.size() - rx_base), 32'd2);
                check("clk_rx0", rx_q[rx_base], 32'h0);
                check("clk_rx1", rx_q[rx_base+1], 32'h0);
                check_idle_outputs("stop0");

                // Single preloaded word
                rx_base = rx_q.size();
                load_word(32'hA5A5_5A5A);
                check("single_ready_low", 32'(bus.s_ready), 32'd0);
                en = 1'b1;
                repeat (256) @(negedge m_clk);
                en = 1'b0;
                repeat (20) @(negedge m_clk);
                check("single_frames", 32'(rx_q.size() - rx_base), 32'd1);
                check("single_word", rx_q[rx_base], 32'hA5A5_5A5A);
                check("single_left", 32'(rx_q[rx_base] >> 16), 32'h0000_A5A5);

                // Streaming back-to-back words
                rx_base = rx_q.size(); ur_base = ur_cnt;
                send(32'h0001_8000);
                fork
                    begin en = 1'b1; repeat (768) @(negedge m_clk); en = 1'b0; end
                    begin send(32'hFFFF_0000); send(32'h1234_5678); end
                join
                repeat (20) @(negedge m_clk);
                check("stream_frames", 32'(rx_q.size() - rx_base), 32'd3);
                check("stream_w0", rx_q[rx_base],   32'h0001_8000);
                check("stream_w1", rx_q[rx_base+1], 32'hFFFF_0000);
                check("stream_w2", rx_q[rx_base+2], 32'h1234_5678);
                check("stream_ur", 32'(ur_cnt - ur_base), 32'd0);

                // Late data: offered on the very frame-start edge
                rx_base = rx_q.size(); ur_base = ur_cnt;
                en = 1'b1;
                load_word(32'hC3C3_3C3C);
                repeat (511) @(negedge m_clk);
                en = 1'b0;
                repeat (20) @(negedge m_clk);
                check("late_frames", 32'(rx_q.size() - rx_base), 32'd2);
                check("late_zero", rx_q[rx_base], 32'h0);
                check("late_word", rx_q[rx_base+1], 32'hC3C3_3C3C);
                check("late_ur", 32'(ur_cnt - ur_base), 32'd1);

                // Stop at bit 5, then a word accepted while idle
                rx_base = rx_q.size();
                load_word(32'hDEAD_BEEF);
                en = 1'b1;
                repeat (42) @(negedge m_clk);
                en = 1'b0;
                repeat (260) @(negedge m_clk);
                check_idle_outputs("stop1");
                bus.s_data  = 32'h0F0F_F0F0;
                bus.s_valid = 1'b1;
                repeat (3) @(negedge m_clk);
                bus.s_valid = 1'b0;
                check("idle_accept_full", 32'(bus.s_ready), 32'd0);
                en = 1'b1;
                repeat (256) @(negedge m_clk);
                en = 1'b0;
                repeat (20) @(negedge m_clk);
                check("stop_frames", 32'(rx_q.size() - rx_base), 32'd2);
                check("stop_word", rx_q[rx_base], 32'hDEAD_BEEF);
                check("idle_word", rx_q[rx_base+1], 32'h0F0F_F0F0);

                // Reset mid-frame at bit 20
                load_word(32'h1357_9BDF);
                en = 1'b1;
                repeat (162) @(negedge m_clk);
                rst_n = 1'b0;
                #1;
                check_idle_outputs("midrst");
                check("midrst_ready", 32'(bus.s_ready), 32'd1);
                repeat (2) @(negedge m_clk);
                rx_base = rx_q.size(); ur_base = ur_cnt;
                rst_n = 1'b1;
                @(negedge m_clk);
                load_word(32'h2468_ACE0);
                repeat (510) @(negedge m_clk);
                en = 1'b0;
                repeat (20) @(negedge m_clk);
                check("rst_frames", 32'(rx_q.size() - rx_base), 32'd2);
                check("rst_zero", rx_q[rx_base], 32'h0);
                check("rst_word", rx_q[rx_base+1], 32'h2468_ACE0);
                check("rst_ur", 32'(ur_cnt - ur_base), 32'd1);

                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        join_any
    end

endmodule
